// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types and constants for the common data bus (CDB) arbiter: source
// encoding, default widths, the holding-slot entry layout and the round-robin
// pointer advance helper.
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int CDB_NUM_SRC  = 5;
    localparam int CDB_DATA_W   = 32;
    localparam int CDB_ROB_IX_W = 3;
    localparam int CDB_SRC_W    = 3;

    // Functional-unit source index order on the CDB request vector.
    typedef enum logic [2:0] {
        SRC_ALU   = 3'd0,
        SRC_BRALU = 3'd1,
        SRC_MUL   = 3'd2,
        SRC_DIV   = 3'd3,
        SRC_MEM   = 3'd4
    } cdb_src_e;

    // One holding-slot payload: result value and its ROB index.
    typedef struct packed {
        logic signed [31:0] value;
        logic [2:0]         rob_ix;
    } cdb_entry_t;

    // Pointer position just after the winner, wrapping n-1 back to 0.
    function automatic int rr_next(input int winner, input int n);
        if (winner >= n - 1) begin
            return 0;
        end else begin
            return winner + 1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Scans req starting at rr_ptr and
// wrapping modulo N; the first set request wins. The pointer itself is kept
// by the caller.
// Ports:
//   req       in  [N-1:0]   request vector
//   rr_ptr    in  [IW-1:0]  scan start position (expected < N)
//   grant     out [N-1:0]   one-hot grant (all zero when no request)
//   grant_ix  out [IW-1:0]  encoded winner index (0 when no request)
//   any_grant out           at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_ix,
    output logic          any_grant
);

    // Priority scan from rr_ptr; the modulo keeps the index in range even if
    // the pointer were ever out of range.
    always_comb begin
        int k;
        k         = 0;
        grant     = '0;
        grant_ix  = '0;
        any_grant = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(rr_ptr) + i) % N;
            if (!any_grant && req[k]) begin
                grant[k]  = 1'b1;
                grant_ix  = IW'(k);
                any_grant = 1'b1;
            end else begin
                any_grant = any_grant;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Common data bus stage behind the functional units. Each unit owns a
// one-entry holding slot; one occupied slot per cycle is granted round-robin
// and its result is broadcast on registered CDB outputs the next cycle.
// Ports:
//   clk_in          in   system clock
//   rst_in          in   asynchronous active-high reset
//   src_valid_in    in   [NUM_SRC]          per-unit result valid
//   src_value_in    in   [NUM_SRC][DATA_W]  per-unit result value
//   src_rob_ix_in   in   [NUM_SRC][ROB_IX_W] per-unit ROB index
//   src_ready_out   out  [NUM_SRC]          slot can accept this cycle
//   flush_in        in   discard everything in flight
//   cdb_valid_out   out  broadcast valid (one cycle per result)
//   cdb_value_out   out  [DATA_W]   broadcast value
//   cdb_rob_ix_out  out  [ROB_IX_W] broadcast ROB index
//   cdb_src_out     out  [3]        source that produced the broadcast
// ---------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC  = CDB_NUM_SRC,
    parameter int DATA_W   = CDB_DATA_W,
    parameter int ROB_IX_W = CDB_ROB_IX_W
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [NUM_SRC-1:0]                 src_valid_in,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]     src_value_in,
    input  logic [NUM_SRC-1:0][ROB_IX_W-1:0]   src_rob_ix_in,
    output logic [NUM_SRC-1:0]                 src_ready_out,
    input  logic                               flush_in,
    output logic                               cdb_valid_out,
    output logic [DATA_W-1:0]                  cdb_value_out,
    output logic [ROB_IX_W-1:0]                cdb_rob_ix_out,
    output logic [CDB_SRC_W-1:0]               cdb_src_out
);

    localparam int IX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] slot_valid;
    cdb_entry_t         slot_entry [NUM_SRC];
    logic [IX_W-1:0]    rr_ptr;

    logic [NUM_SRC-1:0] grant;
    logic [IX_W-1:0]    win_ix;
    logic               any_grant;
    logic [NUM_SRC-1:0] accept;

    rr_arbiter #(
        .N  (NUM_SRC),
        .IW (IX_W)
    ) u_rr (
        .req       (slot_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_ix  (win_ix),
        .any_grant (any_grant)
    );

    // A slot being drained this cycle can take a new result at the same edge.
    // Grant comes only from registered state, so ready never depends on valid.
    assign src_ready_out = ~slot_valid | grant;
    assign accept        = src_valid_in & src_ready_out;

    // Holding slots: flush drops everything, an accept (re)loads, a grant drains.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_valid <= '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                slot_entry[k] <= '0;
            end
        end else if (flush_in) begin
            slot_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (accept[k]) begin
                    slot_valid[k]        <= 1'b1;
                    slot_entry[k].value  <= src_value_in[k];
                    slot_entry[k].rob_ix <= src_rob_ix_in[k];
                end else if (grant[k]) begin
                    slot_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Registered CDB broadcast and round-robin pointer. Data outputs hold
    // their last value when nothing is granted; only valid drops.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cdb_valid_out  <= 1'b0;
            cdb_value_out  <= '0;
            cdb_rob_ix_out <= '0;
            cdb_src_out    <= '0;
            rr_ptr         <= '0;
        end else if (flush_in) begin
            cdb_valid_out <= 1'b0;
            rr_ptr        <= '0;
        end else if (any_grant) begin
            cdb_valid_out  <= 1'b1;
            cdb_value_out  <= slot_entry[win_ix].value;
            cdb_rob_ix_out <= slot_entry[win_ix].rob_ix;
            cdb_src_out    <= CDB_SRC_W'(win_ix);
            rr_ptr         <= IX_W'(rr_next(int'(win_ix), NUM_SRC));
        end else begin
            cdb_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter. Expected broadcasts are queued when a
// result is presented; a negedge monitor pops and compares each broadcast and
// flags any broadcast when nothing is expected.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       src_valid;
    logic [4:0][31:0] src_value;
    logic [4:0][2:0]  src_rob;
    logic [4:0]       src_ready;
    logic             flush;
    logic             cdb_valid;
    logic [31:0]      cdb_value;
    logic [2:0]       cdb_rob;
    logic [2:0]       cdb_src;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] value;
        logic [2:0]  rob_ix;
        logic [2:0]  src;
    } exp_t;

    exp_t sb_q[$];

    cdb_arbiter dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .src_valid_in   (src_valid),
        .src_value_in   (src_value),
        .src_rob_ix_in  (src_rob),
        .src_ready_out  (src_ready),
        .flush_in       (flush),
        .cdb_valid_out  (cdb_valid),
        .cdb_value_out  (cdb_value),
        .cdb_rob_ix_out (cdb_rob),
        .cdb_src_out    (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int k, input logic [31:0] v, input logic [2:0] r, input bit expect_bcast);
        exp_t e;
        src_valid[k] = 1'b1;
        src_value[k] = v;
        src_rob[k]   = r;
        if (expect_bcast) begin
            e.value  = v;
            e.rob_ix = r;
            e.src    = 3'(k);
            sb_q.push_back(e);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Scoreboard monitor: compare every broadcast against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sb_q.size() == 0) begin
                check("unexp_bcast", 64'(cdb_valid), 64'd0);
            end else if (cdb_valid) begin
                e = sb_q.pop_front();
                check("sb_value", 64'(cdb_value), 64'(e.value));
                check("sb_rob_ix", 64'(cdb_rob), 64'(e.rob_ix));
                check("sb_src", 64'(cdb_src), 64'(e.src));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int alu_v;
        int mem_v;
        logic [4:0] exp_rdy;

        src_valid = '0;
        src_value = '0;
        src_rob   = '0;
        flush     = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #3;
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_value", 64'(cdb_value), 64'd0);
        check("rst_rob_ix", 64'(cdb_rob), 64'd0);
        check("rst_src", 64'(cdb_src), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(src_ready), 64'h1F);

        // Single source: accepted end of N, broadcast in N+2 only
        present(0, 32'h0000_002A, 3'd3, 1'b1);
        step();
        src_valid = '0;
        check("t1_no_bypass", 64'(cdb_valid), 64'd0);
        step();
        check("t1_bcast", 64'(cdb_valid), 64'd1);
        step();
        check("t1_one_cycle", 64'(cdb_valid), 64'd0);

        // Contention: all five at once from rr_ptr=0
        do_flush();
        check("t2_ptr_start", 64'(dut.rr_ptr), 64'd0);
        for (int k = 0; k < 5; k++) begin
            present(k, 32'(100 + k), 3'(k), 1'b1);
        end
        step();
        src_valid = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_valid", 64'(cdb_valid), 64'd1);
            check("t2_order", 64'(cdb_src), 64'(i));
        end
        step();
        check("t2_idle", 64'(cdb_valid), 64'd0);
        check("t2_ptr_wrap", 64'(dut.rr_ptr), 64'd0);

        // Back-to-back results on mul
        for (int i = 0; i < 3; i++) begin
            present(2, 32'(7 + i), 3'(4 + i), 1'b1);
            check("t3_ready", 64'(src_ready[2]), 64'd1);
            step();
            check("t3_valid", 64'(cdb_valid), (i > 0) ? 64'd1 : 64'd0);
        end
        src_valid = '0;
        step();
        check("t3_last", 64'(cdb_valid), 64'd1);
        step();
        check("t3_idle", 64'(cdb_valid), 64'd0);

        // Fairness: alu and mem continuously valid, must alternate
        do_flush();
        alu_v = 200;
        mem_v = 300;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                exp_rdy = 5'b11111;
            end else if (i % 2 == 1) begin
                exp_rdy = 5'b01111;
            end else begin
                exp_rdy = 5'b11110;
            end
            check("t4_ready", 64'(src_ready), 64'(exp_rdy));
            present(0, 32'(alu_v), 3'd1, exp_rdy[0]);
            present(4, 32'(mem_v), 3'd5, exp_rdy[4]);
            step();
            if (exp_rdy[0]) alu_v++;
            if (exp_rdy[4]) mem_v++;
        end
        src_valid = '0;
        step();
        step();
        step();
        check("t4_idle", 64'(cdb_valid), 64'd0);

        // Flush with slots 1 and 3 held and div presenting
        present(1, 32'h0000_0111, 3'd2, 1'b0);
        present(3, 32'h0000_0333, 3'd6, 1'b0);
        step();
        src_valid = '0;
        present(3, 32'h0000_0444, 3'd7, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        src_valid = '0;
        check("t5_valid", 64'(cdb_valid), 64'd0);
        check("t5_ptr", 64'(dut.rr_ptr), 64'd0);
        check("t5_ready", 64'(src_ready), 64'h1F);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_bcast", 64'(cdb_valid), 64'd0);
        end

        // Async reset while a broadcast is on the bus
        present(0, 32'h0000_0037, 3'd2, 1'b1);
        step();
        src_valid = '0;
        present(4, 32'h0000_0042, 3'd5, 1'b0);
        step();
        src_valid = '0;
        check("t6_pre_valid", 64'(cdb_valid), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", 64'(cdb_valid), 64'd0);
        check("t6_async_value", 64'(cdb_value), 64'd0);
        check("t6_async_src", 64'(cdb_src), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("t6_ready", 64'(src_ready), 64'h1F);
        check("t6_ptr", 64'(dut.rr_ptr), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_bcast", 64'(cdb_valid), 64'd0);
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
